// File: rtl/control_word_profiler_pkg.sv
// Control word field positions, class codes and class patterns for the control word profiler.
// Shared by the profiler top and its counter sub-module.
package control_word_profiler_pkg;

    typedef enum logic [3:0] {
        CLS_NOP     = 4'd0,
        CLS_RTYPE   = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_IMM     = 4'd4,
        CLS_SETI    = 4'd5,
        CLS_JUMP    = 4'd6,
        CLS_BRANCH  = 4'd7,
        CLS_ILLEGAL = 4'd15
    } cls_e;

    localparam int BIT_EXC = 3;

    localparam logic [10:0] PAT_NOP      = 11'h000;
    localparam logic [10:0] PAT_RTYPE    = 11'h023;
    localparam logic [10:0] PAT_LOAD     = 11'h146;
    localparam logic [10:0] PAT_STORE    = 11'h084;
    localparam logic [10:0] PAT_IMM      = 11'h037;
    localparam logic [10:0] PAT_SETI     = 11'h007;
    localparam logic [10:0] PAT_JUMP     = 11'h400;
    localparam logic [10:0] PAT_BRANCH   = 11'h210;
    // SETI and JUMP do not care about the ALUop field
    localparam logic [10:0] MSK_ALUOP_DC = 11'h7CF;

    localparam int NUM_CNT     = 10;
    localparam int IDX_ILLEGAL = 8;
    localparam int IDX_TOTAL   = 9;

endpackage

// File: rtl/control_word_profiler_sat_counter.sv
// Saturating event counter: increments on inc, holds at all-ones, synchronous clear.
module control_word_profiler_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/control_word_profiler.sv
// Debug monitor that classifies sampled control words and keeps per-class saturating counters.
// Define CTRL_PROF_CAPTURE_EN to capture the first illegal control word into illegal_cw.
module control_word_profiler
    import control_word_profiler_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int CW_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cw_valid,
    input  logic [CW_W-1:0]  control_signal,
    input  logic             clr,
    input  logic [3:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic [3:0]       class_out,
    output logic             class_valid,
    output logic             illegal_sticky,
    output logic [CW_W-1:0]  illegal_cw
);

    function automatic cls_e encode(input logic [CW_W-1:0] cw);
        if (cw[BIT_EXC])                          return CLS_ILLEGAL;
        if (cw == PAT_NOP)                        return CLS_NOP;
        if (cw == PAT_RTYPE)                      return CLS_RTYPE;
        if (cw == PAT_LOAD)                       return CLS_LOAD;
        if (cw == PAT_STORE)                      return CLS_STORE;
        if (cw == PAT_IMM)                        return CLS_IMM;
        if ((cw & MSK_ALUOP_DC) == PAT_SETI)      return CLS_SETI;
        if ((cw & MSK_ALUOP_DC) == PAT_JUMP)      return CLS_JUMP;
        if (cw == PAT_BRANCH)                     return CLS_BRANCH;
        return CLS_ILLEGAL;
    endfunction

    cls_e             cls;
    logic [3:0]       cidx;
    logic             sample;
    logic [CNT_W-1:0] cnt [NUM_CNT];
    logic [CNT_W-1:0] rd_next;

    assign cls    = encode(control_signal);
    assign cidx   = (cls == CLS_ILLEGAL) ? 4'(IDX_ILLEGAL) : {1'b0, cls[2:0]};
    // clr wins over a coincident sample, so nothing is counted on a clearing edge
    assign sample = cw_valid && !clr;

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        logic inc;
        assign inc = sample && ((i == IDX_TOTAL) || (cidx == 4'(i)));

        control_word_profiler_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc),
            .clr   (clr),
            .count (cnt[i])
        );
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel == 4'(i)) rd_next = cnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data        <= '0;
            class_out      <= '0;
            class_valid    <= 1'b0;
            illegal_sticky <= 1'b0;
        end else begin
            rd_data <= rd_next;
            if (clr) begin
                class_out      <= '0;
                class_valid    <= 1'b0;
                illegal_sticky <= 1'b0;
            end else begin
                class_valid <= cw_valid;
                if (cw_valid) begin
                    class_out <= cls;
                    if (cls == CLS_ILLEGAL) illegal_sticky <= 1'b1;
                end
            end
        end
    end

`ifdef CTRL_PROF_CAPTURE_EN
    // illegal_sticky doubles as the "already captured" flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cw <= '0;
        end else if (clr) begin
            illegal_cw <= '0;
        end else if (cw_valid && (cls == CLS_ILLEGAL) && !illegal_sticky) begin
            illegal_cw <= control_signal;
        end
    end
`else
    assign illegal_cw = '0;
`endif

endmodule

// File: tb/tb_control_word_profiler.sv
// Randomized self-checking bench for control_word_profiler (32-bit and 4-bit counter instances).
module tb_control_word_profiler;

`ifdef CTRL_PROF_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cw_valid = 1'b0;
    logic        clr = 1'b0;
    logic [10:0] control_signal = '0;
    logic [3:0]  rd_sel = '0;

    logic [31:0] rd_data;
    logic [3:0]  class_out;
    logic        class_valid, illegal_sticky;
    logic [10:0] illegal_cw;
    logic [3:0]  rd_data4, class_out4;
    logic        class_valid4, illegal_sticky4;
    logic [10:0] illegal_cw4;

    int checks = 0;
    int failures = 0;

    // reference model state
    int          mcnt [10];
    logic [3:0]  mclass;
    bit          mvalid, msticky;
    logic [10:0] mcap;
    int          exp_rd;

    always #5 clk = ~clk;

    control_word_profiler #(.CNT_W(32), .CW_W(11)) u_dut (
        .clk(clk), .rst(rst), .cw_valid(cw_valid), .control_signal(control_signal),
        .clr(clr), .rd_sel(rd_sel), .rd_data(rd_data), .class_out(class_out),
        .class_valid(class_valid), .illegal_sticky(illegal_sticky), .illegal_cw(illegal_cw)
    );

    control_word_profiler #(.CNT_W(4), .CW_W(11)) u_dut4 (
        .clk(clk), .rst(rst), .cw_valid(cw_valid), .control_signal(control_signal),
        .clr(clr), .rd_sel(rd_sel), .rd_data(rd_data4), .class_out(class_out4),
        .class_valid(class_valid4), .illegal_sticky(illegal_sticky4), .illegal_cw(illegal_cw4)
    );

    // classification written from the field meanings of the control word
    function automatic logic [3:0] mclassify(input logic [10:0] cw);
        logic       jmp, br, mrd, mwr, m2r, exc, src, rw, rdst;
        logic [1:0] op;
        {jmp, br, mrd, mwr, m2r, op, exc, src, rw, rdst} = cw;
        if (exc) return 4'd15;
        if (cw == 11'h000) return 4'd0;
        if (!jmp && !br && !mrd && !mwr && !m2r && op == 2'b10 && !src && rw && rdst) return 4'd1;
        if (!jmp && !br && mrd && !mwr && m2r && op == 2'b00 && src && rw && !rdst) return 4'd2;
        if (!jmp && !br && !mrd && mwr && !m2r && op == 2'b00 && src && !rw && !rdst) return 4'd3;
        if (!jmp && !br && !mrd && !mwr && !m2r && op == 2'b11 && src && rw && rdst) return 4'd4;
        if (!jmp && !br && !mrd && !mwr && !m2r && src && rw && rdst) return 4'd5;
        if (jmp && !br && !mrd && !mwr && !m2r && !src && !rw && !rdst) return 4'd6;
        if (!jmp && br && !mrd && !mwr && !m2r && op == 2'b01 && !src && !rw && !rdst) return 4'd7;
        return 4'd15;
    endfunction

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    function automatic logic [10:0] exp_cap();
        return CAP ? mcap : 11'h000;
    endfunction

    task automatic model_reset();
        foreach (mcnt[i]) mcnt[i] = 0;
        mclass = '0; mvalid = 1'b0; msticky = 1'b0; mcap = '0; exp_rd = 0;
    endtask

    // drive one cycle, advance the model, return #1 after the sampling edge
    task automatic step(input bit v, input logic [10:0] cw, input bit c, input logic [3:0] sel);
        logic [3:0] k;
        @(negedge clk);
        cw_valid = v; control_signal = cw; clr = c; rd_sel = sel;
        exp_rd = (sel < 10) ? mcnt[sel] : 0;
        if (c) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            mclass = '0; mvalid = 1'b0; msticky = 1'b0; mcap = '0;
        end else begin
            mvalid = v;
            if (v) begin
                k = mclassify(cw);
                mclass = k;
                mcnt[(k == 4'd15) ? 8 : int'(k)]++;
                mcnt[9]++;
                if (k == 4'd15) begin
                    if (!msticky) mcap = cw;
                    msticky = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cw_valid = 1'b0; clr = 1'b0; control_signal = '0;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
        checks++; if (class_out !== 4'd0) begin failures++; $display("FAIL reset_class_out got=%0h exp=0", class_out); end
        checks++; if (class_valid !== 1'b0) begin failures++; $display("FAIL reset_class_valid got=%0b exp=0", class_valid); end
        checks++; if (illegal_sticky !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%0b exp=0", illegal_sticky); end
        checks++; if (illegal_cw !== 11'h000) begin failures++; $display("FAIL reset_illegal_cw got=%0h exp=0", illegal_cw); end
        checks++; if (rd_data4 !== 4'd0) begin failures++; $display("FAIL reset_rd_data4 got=%0h exp=0", rd_data4); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_classes();
        logic [10:0] seq [6] = '{11'h023, 11'h146, 11'h084, 11'h037, 11'h210, 11'h000};
        logic [3:0]  cls [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd0};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, seq[i], 1'b0, 4'($urandom_range(0, 15)));
            checks++;
            if (class_out !== cls[i] || class_valid !== 1'b1 || class_out !== mclass) begin
                failures++;
                $display("FAIL class_seq[%0d] got=%0d/%0b exp=%0d/1", i, class_out, class_valid, cls[i]);
            end
        end
        step(1'b0, 11'h000, 1'b0, 4'd0);
        checks++; if (class_valid !== 1'b0 || class_out !== 4'd0) begin failures++; $display("FAIL class_hold got=%0d/%0b exp=0/0", class_out, class_valid); end
        for (int s = 0; s < 16; s++) begin
            step(1'b0, 11'h000, 1'b0, 4'(s));
            checks++;
            if (rd_data !== 32'(exp_rd) || exp_rd != ((s == 9) ? 6 : (s < 8 && s != 5 && s != 6) ? 1 : 0)) begin
                failures++;
                $display("FAIL class_count[%0d] got=%0d exp=%0d", s, rd_data, exp_rd);
            end
        end
    endtask

    task automatic test_seti_jump();
        logic [10:0] seq [3] = '{11'h420, 11'h410, 11'h027};
        logic [3:0]  cls [3] = '{4'd6, 4'd6, 4'd5};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, seq[i], 1'b0, 4'd0);
            checks++;
            if (class_out !== cls[i]) begin failures++; $display("FAIL seti_jump[%0d] got=%0d exp=%0d", i, class_out, cls[i]); end
        end
        step(1'b0, 11'h000, 1'b0, 4'd6);
        checks++; if (rd_data !== 32'd2) begin failures++; $display("FAIL jump_count got=%0d exp=2", rd_data); end
    endtask

    task automatic do_reset_check(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        checks++;
        if (rd_data !== 32'd0 || class_out !== 4'd0 || class_valid !== 1'b0 || illegal_sticky !== 1'b0 || illegal_cw !== 11'h000) begin
            failures++;
            $display("FAIL %s_async got=%0h/%0h/%0b/%0b/%0h exp=all zero", tag, rd_data, class_out, class_valid, illegal_sticky, illegal_cw);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_illegal();
        do_reset_check("illegal_pre");
        step(1'b1, 11'h180, 1'b0, 4'd0);
        checks++; if (class_out !== 4'd15 || illegal_sticky !== 1'b1) begin failures++; $display("FAIL illegal_first got=%0d/%0b exp=15/1", class_out, illegal_sticky); end
        step(1'b1, 11'h02B, 1'b0, 4'd0);
        checks++; if (class_out !== 4'd15 || illegal_sticky !== 1'b1) begin failures++; $display("FAIL illegal_exc got=%0d/%0b exp=15/1", class_out, illegal_sticky); end
        step(1'b0, 11'h000, 1'b0, 4'd8);
        checks++; if (rd_data !== 32'd2) begin failures++; $display("FAIL illegal_count got=%0d exp=2", rd_data); end
        checks++; if (illegal_cw !== (CAP ? 11'h180 : 11'h000)) begin failures++; $display("FAIL illegal_capture got=%0h exp=%0h", illegal_cw, exp_cap()); end
    endtask

    task automatic test_saturation();
        do_reset_check("sat_pre");
        for (int i = 0; i < 20; i++) step(1'b1, 11'h023, 1'b0, 4'd1);
        step(1'b0, 11'h000, 1'b0, 4'd1);
        checks++; if (rd_data !== 32'd20) begin failures++; $display("FAIL sat_cnt32 got=%0d exp=20", rd_data); end
        checks++; if (rd_data4 !== 4'd15) begin failures++; $display("FAIL sat_cnt4 got=%0d exp=15", rd_data4); end
        step(1'b0, 11'h000, 1'b0, 4'd9);
        checks++; if (rd_data4 !== 4'd15 || rd_data !== 32'd20) begin failures++; $display("FAIL sat_total got=%0d/%0d exp=15/20", rd_data4, rd_data); end
    endtask

    task automatic test_clear();
        step(1'b1, 11'h180, 1'b0, 4'd0);
        step(1'b1, 11'h146, 1'b1, 4'd1);
        checks++;
        if (class_valid !== 1'b0 || class_out !== 4'd0 || illegal_sticky !== 1'b0 || illegal_cw !== 11'h000) begin
            failures++;
            $display("FAIL clear_flags got=%0b/%0d/%0b/%0h exp=0/0/0/0", class_valid, class_out, illegal_sticky, illegal_cw);
        end
        for (int s = 0; s < 10; s++) begin
            step(1'b0, 11'h000, 1'b0, 4'(s));
            checks++; if (rd_data !== 32'd0 || rd_data4 !== 4'd0) begin failures++; $display("FAIL clear_count[%0d] got=%0d exp=0", s, rd_data); end
        end
    endtask

    task automatic test_reset_midburst();
        step(1'b1, 11'h023, 1'b0, 4'd1);
        step(1'b1, 11'h180, 1'b0, 4'd1);
        do_reset_check("midburst");
        step(1'b1, 11'h023, 1'b0, 4'd1);
        step(1'b0, 11'h000, 1'b0, 4'd1);
        checks++; if (rd_data !== 32'd1) begin failures++; $display("FAIL midburst_restart got=%0d exp=1", rd_data); end
        step(1'b0, 11'h000, 1'b0, 4'd8);
        checks++; if (rd_data !== 32'd0 || illegal_sticky !== 1'b0) begin failures++; $display("FAIL midburst_illegal got=%0d/%0b exp=0/0", rd_data, illegal_sticky); end
    endtask

    task automatic test_random();
        logic [10:0] legal [8] = '{11'h000, 11'h023, 11'h146, 11'h084, 11'h037, 11'h027, 11'h420, 11'h210};
        logic [10:0] cw;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: cw = 11'($urandom);
                2: cw = legal[$urandom_range(0, 7)] ^ (11'd1 << $urandom_range(0, 10));
                default: cw = legal[$urandom_range(0, 7)] | {5'd0, 2'($urandom), 4'd0};
            endcase
            step($urandom_range(0, 3) != 0, cw, $urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)));
            checks++;
            if (class_out !== mclass || class_valid !== mvalid || illegal_sticky !== msticky ||
                illegal_cw !== exp_cap() || rd_data !== 32'(exp_rd) || rd_data4 !== 4'(sat4(exp_rd))) begin
                failures++;
                $display("FAIL random[%0d] cw=%0h got=%0d/%0b/%0b/%0h/%0d/%0d exp=%0d/%0b/%0b/%0h/%0d/%0d",
                         n, cw, class_out, class_valid, illegal_sticky, illegal_cw, rd_data, rd_data4,
                         mclass, mvalid, msticky, exp_cap(), exp_rd, sat4(exp_rd));
            end
        end
    endtask

    initial begin
        test_reset();
        test_classes();
        test_seti_jump();
        test_illegal();
        test_saturation();
        test_clear();
        test_reset_midburst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
